// File: rtl/mux_2to1_pkg.sv
// Shared types, defaults and helpers for the registered 2:1 selector.
// Parity helper is used only when MUX_2TO1_PARITY_EN is defined.
package mux_2to1_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  // Widest word the parity helper folds; narrower words are zero-extended.
  localparam int unsigned PARITY_MAX_W       = 256;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  function automatic logic parity_f(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mux_2to1_if.sv
// Single valid/ready channel carrying a W-bit payload.
interface mux_2to1_if #(
  parameter int unsigned W = 8
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/mux_2to1_skid.sv
// One-entry skid buffer in front of an output register; every output is a flop,
// and the upstream ready has no combinational path from the downstream ready.
module mux_2to1_skid #(
  parameter int unsigned W = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  mux_2to1_if.slave  slv_if,
  mux_2to1_if.master mst_if
);

  logic [W-1:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic         ready_q, ready_d;
  logic         accept;
  logic         consume;

  assign accept  = slv_if.valid && ready_q;
  assign consume = out_valid_q && mst_if.ready;

  // Next state: drain skid on consume, then place any new word in the first free slot.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;

    if (consume) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d  = 1'b0;
      end
    end

    if (accept) begin
      if (!out_valid_q || consume) begin
        out_data_d   = slv_if.data;
        out_valid_d  = 1'b1;
      end else begin
        skid_data_d  = slv_if.data;
        skid_valid_d = 1'b1;
      end
    end

    ready_d = !skid_valid_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign slv_if.ready = ready_q;
  assign mst_if.data  = out_data_q;
  assign mst_if.valid = out_valid_q;

endmodule

// File: rtl/mux_2to1.sv
// Registered, flow-controlled 2:1 word selector feeding a one-entry skid buffer.
// Define MUX_2TO1_PARITY_EN to add a registered o_parity output (XOR of o_y).
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_sel,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic                  o_valid,
  input  logic                  i_ready
`ifdef MUX_2TO1_PARITY_EN
  ,
  output logic                  o_parity
`endif
);

`ifdef MUX_2TO1_PARITY_EN
  localparam int unsigned PAYLOAD_W = DATA_WIDTH + 1;
`else
  localparam int unsigned PAYLOAD_W = DATA_WIDTH;
`endif

  logic [DATA_WIDTH-1:0] sel_data;

  mux_2to1_if #(.W(PAYLOAD_W)) up_if ();
  mux_2to1_if #(.W(PAYLOAD_W)) dn_if ();

  always_comb sel_data = (sel_e'(i_sel) == SEL_B) ? i_b : i_a;

  // Parity travels with its word through the skid so it always lines up with o_y.
`ifdef MUX_2TO1_PARITY_EN
  assign up_if.data = {parity_f(PARITY_MAX_W'(sel_data)), sel_data};
  assign o_parity   = dn_if.data[DATA_WIDTH];
`else
  assign up_if.data = sel_data;
`endif

  assign up_if.valid = i_valid;
  assign o_ready     = up_if.ready;
  assign o_y         = dn_if.data[DATA_WIDTH-1:0];
  assign o_valid     = dn_if.valid;
  assign dn_if.ready = i_ready;

  mux_2to1_skid #(.W(PAYLOAD_W)) u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .slv_if (up_if),
    .mst_if (dn_if)
  );

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1 at widths 8, 1 and 32 sharing one handshake.
// Parity is checked when MUX_2TO1_PARITY_EN is defined.
module tb_mux_2to1;

  logic        clk;
  logic        rst;
  logic        vld;
  logic        rdy;
  logic        sel;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic [0:0]  a1, b1;

  logic        or8, or1, or32;
  logic        ov1, ov32;
  logic [0:0]  y1;
  logic [31:0] y32;
  logic [7:0]  y8;
  logic        ov8;
  logic        p8, p1, p32;

  int n_chk  = 0;
  int n_pass = 0;

  logic [32:0] q8[$];
  logic [32:0] q1[$];
  logic [32:0] q32[$];
  logic        hold8;
  logic [32:0] hold_y8;

  mux_2to1_if #(.W(8)) dn8_if ();

  assign a1          = a8[0:0];
  assign b1          = b8[0:0];
  assign dn8_if.ready = rdy;
  assign y8          = dn8_if.data;
  assign ov8         = dn8_if.valid;
`ifndef MUX_2TO1_PARITY_EN
  assign p8  = 1'b0;
  assign p1  = 1'b0;
  assign p32 = 1'b0;
`endif

  mux_2to1 #(.DATA_WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_a(a8), .i_b(b8), .i_sel(sel), .i_valid(vld),
    .o_ready(or8), .o_y(dn8_if.data), .o_valid(dn8_if.valid), .i_ready(rdy)
`ifdef MUX_2TO1_PARITY_EN
    , .o_parity(p8)
`endif
  );

  mux_2to1 #(.DATA_WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_a(a1), .i_b(b1), .i_sel(sel), .i_valid(vld),
    .o_ready(or1), .o_y(y1), .o_valid(ov1), .i_ready(rdy)
`ifdef MUX_2TO1_PARITY_EN
    , .o_parity(p1)
`endif
  );

  mux_2to1 #(.DATA_WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_a(a32), .i_b(b32), .i_sel(sel), .i_valid(vld),
    .o_ready(or32), .o_y(y32), .o_valid(ov32), .i_ready(rdy)
`ifdef MUX_2TO1_PARITY_EN
    , .o_parity(p32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] act, input logic [32:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Expected output word: parity bit (when enabled) over the selected operand.
  function automatic logic [32:0] exp_word(input logic [31:0] y);
`ifdef MUX_2TO1_PARITY_EN
    return {^y, y};
`else
    return {1'b0, y};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop/compare on a consume, push on an accept, check hold while stalled.
  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      q1.delete();
      q32.delete();
      hold8 = 1'b0;
    end else begin
      if (hold8) begin
        check("hold_valid8", 33'(ov8), 33'(1));
        check("hold_y8", {p8, 32'(y8)}, hold_y8);
      end
      hold8   = ov8 && !rdy;
      hold_y8 = {p8, 32'(y8)};

      if (ov8 && rdy) begin
        if (q8.size() == 0) check("sb8_nonempty", 33'(q8.size()), 33'(1));
        else check("sb8", {p8, 32'(y8)}, q8.pop_front());
      end
      if (ov1 && rdy) begin
        if (q1.size() == 0) check("sb1_nonempty", 33'(q1.size()), 33'(1));
        else check("sb1", {p1, 32'(y1)}, q1.pop_front());
      end
      if (ov32 && rdy) begin
        if (q32.size() == 0) check("sb32_nonempty", 33'(q32.size()), 33'(1));
        else check("sb32", {p32, y32}, q32.pop_front());
      end

      if (vld && or8)  q8.push_back(exp_word(32'(sel ? b8 : a8)));
      if (vld && or1)  q1.push_back(exp_word(32'(sel ? b1 : a1)));
      if (vld && or32) q32.push_back(exp_word(sel ? b32 : a32));
    end
  end

  initial begin
    rst = 1'b1; vld = 1'b0; rdy = 1'b0; sel = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a32 = 32'hDEADBEEF; b32 = 32'h0;
    hold8 = 1'b0; hold_y8 = '0;

    repeat (2) step();
    check("rst_ready", 33'(or8), 33'(1));
    check("rst_valid", 33'(ov8), 33'(0));
    check("rst_y", 33'(y8), 33'(0));
    rst = 1'b0;
    step();
    check("post_rst_ready", 33'(or8), 33'(1));

    // Single transfer on each operand, drained immediately.
    rdy = 1'b1; a8 = 8'h3C; b8 = 8'hC3; sel = 1'b0; vld = 1'b1;
    step();
    vld = 1'b0;
    check("sel_a_valid", 33'(ov8), 33'(1));
    check("sel_a_y", 33'(y8), 33'(8'h3C));
    check("sel_a_y32", 33'(y32), 33'(32'hDEADBEEF));
    step();
    check("drain_valid", 33'(ov8), 33'(0));
    check("drain_y_held", 33'(y8), 33'(8'h3C));

    sel = 1'b1; vld = 1'b1;
    step();
    vld = 1'b0;
    check("sel_b_y", 33'(y8), 33'(8'hC3));
    check("sel_b_y32", 33'(y32), 33'(32'h0));
    check("sel_b_y1", 33'(y1), 33'(1));
    step();

    // Back-to-back alternating select at full rate.
    for (int i = 0; i < 6; i++) begin
      sel = 1'(i % 2); vld = 1'b1;
      step();
      check("b2b_ready", 33'(or8), 33'(1));
      check("b2b_valid", 33'(ov8), 33'(1));
      check("b2b_y", 33'(y8), (i % 2 == 1) ? 33'(8'hC3) : 33'(8'h3C));
    end
    vld = 1'b0;
    step();

    // Stall: fill output and skid, third offer must be refused.
    rdy = 1'b0; sel = 1'b0; a8 = 8'h11; vld = 1'b1;
    step();
    a8 = 8'h22;
    step();
    check("full_ready", 33'(or8), 33'(0));
    check("full_y", 33'(y8), 33'(8'h11));
    a8 = 8'h33;
    step();
    check("refuse_ready", 33'(or8), 33'(0));
    check("refuse_y", 33'(y8), 33'(8'h11));
    vld = 1'b0; rdy = 1'b1;
    step();
    check("unstall_y", 33'(y8), 33'(8'h22));
    check("unstall_ready", 33'(or8), 33'(1));
    step();
    check("unstall_empty", 33'(ov8), 33'(0));

    // Reset while both entries are occupied.
    rdy = 1'b0; a8 = 8'h44; vld = 1'b1;
    step();
    a8 = 8'h55;
    step();
    vld = 1'b0;
    check("pre_flush_ready", 33'(or8), 33'(0));
    rst = 1'b1;
    step();
    check("flush_valid", 33'(ov8), 33'(0));
    check("flush_y", 33'(y8), 33'(0));
    check("flush_ready", 33'(or8), 33'(1));
    check("flush_valid32", 33'(ov32), 33'(0));
    check("flush_y32", 33'(y32), 33'(0));
    rst = 1'b0; rdy = 1'b1;
    step();

    // Parity words.
    sel = 1'b0; a8 = 8'h07; vld = 1'b1;
    step();
    check("par_y07", 33'(y8), 33'(8'h07));
`ifdef MUX_2TO1_PARITY_EN
    check("par_07", 33'(p8), 33'(1));
`endif
    a8 = 8'h03;
    step();
    vld = 1'b0;
    check("par_y03", 33'(y8), 33'(8'h03));
`ifdef MUX_2TO1_PARITY_EN
    check("par_03", 33'(p8), 33'(0));
`endif
    step();

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      vld = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      sel = 1'($urandom_range(0, 1));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a32 = $urandom;
      b32 = $urandom;
      step();
    end

    vld = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 20 && (q8.size() + q1.size() + q32.size()) > 0; k++) step();
    check("drain_q8", 33'(q8.size()), 33'(0));
    check("drain_q1", 33'(q1.size()), 33'(0));
    check("drain_q32", 33'(q32.size()), 33'(0));
    check("final_valid", 33'(ov8), 33'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
